alu_pipe: RTL and testbench

Parametrised, pipelined integer execution unit between the reservation station (RS) and the common data bus (CDB). Accepts one operation per cycle through a valid/ready handshake, computes it in a configurable-depth pipeline, and buffers results in an output queue that drains to the CDB only when the CDB arbiter grants. A flush input discards all in-flight and queued work on ROB clear (branch mispredict).

---
 rtl/alu_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit between the RS and the CDB, with a credit-guarded output queue.
// Optional multiply support is enabled by defining ALU_PIPE_MUL_EN (requires STAGES >= 2).
module alu_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned Q_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [XLEN-1:0]  in_lhs,
    input  logic [XLEN-1:0]  in_rhs,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ROB_W-1:0] in_rob,
    output logic             cdb_valid,
    input  logic             cdb_grant,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [XLEN-1:0]  cdb_result,
    output logic [XLEN-1:0]  cdb_link
);

    localparam logic [5:0] OpAdd   = 6'd1,  OpSub   = 6'd2,  OpXor   = 6'd3,  OpOr    = 6'd4;
    localparam logic [5:0] OpAnd   = 6'd5,  OpSll   = 6'd6,  OpSrl   = 6'd7,  OpSra   = 6'd8;
    localparam logic [5:0] OpSlt   = 6'd9,  OpSltu  = 6'd10, OpAddi  = 6'd11, OpXori  = 6'd12;
    localparam logic [5:0] OpOri   = 6'd13, OpAndi  = 6'd14, OpSlli  = 6'd15, OpSrli  = 6'd16;
    localparam logic [5:0] OpSrai  = 6'd17, OpSlti  = 6'd18, OpSltiu = 6'd19, OpBeq   = 6'd20;
    localparam logic [5:0] OpBne   = 6'd21, OpBlt   = 6'd22, OpBge   = 6'd23, OpBltu  = 6'd24;
    localparam logic [5:0] OpBgeu  = 6'd25, OpJalr  = 6'd26, OpLoad  = 6'd27, OpStore = 6'd28;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [5:0] OpMul   = 6'd29, OpMulh  = 6'd30, OpMulhsu = 6'd31, OpMulhu = 6'd32;
`endif

    localparam int unsigned QW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int unsigned CW = $clog2(Q_DEPTH + 1);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("alu_pipe: STAGES must be in 1..4");
    end
    if (Q_DEPTH < STAGES || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_pipe: Q_DEPTH must be a power of two and >= STAGES");
    end
`ifdef ALU_PIPE_MUL_EN
    if (STAGES < 2) begin : g_bad_mul
        $error("alu_pipe: ALU_PIPE_MUL_EN needs STAGES >= 2");
    end
`endif

    logic acc;
    logic [XLEN-1:0] alu_res, alu_link, sum;
    logic [XLEN-1:0] sra_res;
    logic lt_s, lt_u, eq;

    always_comb begin
        sum      = in_lhs + in_rhs;
        sra_res  = XLEN'($signed(in_lhs) >>> in_rhs[4:0]);
        lt_s     = $signed(in_lhs) < $signed(in_rhs);
        lt_u     = in_lhs < in_rhs;
        eq       = in_lhs == in_rhs;
        alu_res  = '0;
        alu_link = '0;
        case (in_opcode)
            OpAdd, OpAddi, OpLoad, OpStore: alu_res = sum;
            OpSub:            alu_res = in_lhs - in_rhs;
            OpXor, OpXori:    alu_res = in_lhs ^ in_rhs;
            OpOr, OpOri:      alu_res = in_lhs | in_rhs;
            OpAnd, OpAndi:    alu_res = in_lhs & in_rhs;
            OpSll, OpSlli:    alu_res = in_lhs << in_rhs[4:0];
            OpSrl, OpSrli:    alu_res = in_lhs >> in_rhs[4:0];
            OpSra, OpSrai:    alu_res = sra_res;
            OpSlt, OpSlti:    alu_res = XLEN'(lt_s);
            OpSltu, OpSltiu:  alu_res = XLEN'(lt_u);
            OpBeq:            alu_res = XLEN'(eq);
            OpBne:            alu_res = XLEN'(!eq);
            OpBlt:            alu_res = XLEN'(lt_s);
            OpBge:            alu_res = XLEN'(!lt_s);
            OpBltu:           alu_res = XLEN'(lt_u);
            OpBgeu:           alu_res = XLEN'(!lt_u);
            OpJalr: begin
                alu_res  = {sum[XLEN-1:1], 1'b0};
                alu_link = in_pc + XLEN'(4);
            end
            default: ;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    // Full product is registered in stage 1; stage 2 picks the half.
    logic is_mul, mul_hi, a_signed, b_signed;
    logic [2*XLEN-1:0] mul_a, mul_b, prod_d, prod_q;
    logic mul_q, mul_hi_q;

    always_comb begin
        is_mul   = 1'b0;
        mul_hi   = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (in_opcode)
            OpMul:    is_mul = 1'b1;
            OpMulh:   begin is_mul = 1'b1; mul_hi = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
            OpMulhsu: begin is_mul = 1'b1; mul_hi = 1'b1; a_signed = 1'b1; end
            OpMulhu:  begin is_mul = 1'b1; mul_hi = 1'b1; end
            default: ;
        endcase
        mul_a  = {{XLEN{a_signed & in_lhs[XLEN-1]}}, in_lhs};
        mul_b  = {{XLEN{b_signed & in_rhs[XLEN-1]}}, in_rhs};
        prod_d = mul_a * mul_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            mul_q    <= 1'b0;
            mul_hi_q <= 1'b0;
        end else if (rdy) begin
            prod_q   <= prod_d;
            mul_q    <= is_mul;
            mul_hi_q <= mul_hi;
        end
    end
`endif

    logic             valid_q [STAGES];
    logic [ROB_W-1:0] rob_q   [STAGES];
    logic [XLEN-1:0]  res_q   [STAGES];
    logic [XLEN-1:0]  link_q  [STAGES];
    logic [XLEN-1:0]  stage_res [STAGES];

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) stage_res[k] = res_q[k];
`ifdef ALU_PIPE_MUL_EN
        if (mul_q) stage_res[0] = mul_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                rob_q[k]   <= '0;
                res_q[k]   <= '0;
                link_q[k]  <= '0;
            end
        end else if (rdy) begin
            valid_q[0] <= acc;
            rob_q[0]   <= in_rob;
            res_q[0]   <= alu_res;
            link_q[0]  <= alu_link;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1] & ~flush;
                rob_q[k]   <= rob_q[k-1];
                res_q[k]   <= stage_res[k-1];
                link_q[k]  <= link_q[k-1];
            end
        end
    end

    logic [ROB_W-1:0] q_rob  [Q_DEPTH];
    logic [XLEN-1:0]  q_res  [Q_DEPTH];
    logic [XLEN-1:0]  q_link [Q_DEPTH];
    logic [QW-1:0]    rptr_q, wptr_q;
    logic [CW-1:0]    count_q;
    logic             wr, pop;
    int unsigned      occupancy;

    always_comb begin
        occupancy = 32'(count_q);
        for (int unsigned k = 0; k < STAGES; k++) occupancy = occupancy + 32'(valid_q[k]);
    end

    assign in_ready   = rdy & ~flush & (occupancy < Q_DEPTH);
    assign acc        = rdy & in_valid & in_ready & ~flush;
    assign cdb_valid  = (count_q != '0);
    assign wr         = rdy & ~flush & valid_q[STAGES-1];
    assign pop        = rdy & ~flush & cdb_valid & cdb_grant;
    assign cdb_rob    = q_rob[rptr_q];
    assign cdb_result = q_res[rptr_q];
    assign cdb_link   = q_link[rptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                q_rob[i]  <= '0;
                q_res[i]  <= '0;
                q_link[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                rptr_q  <= '0;
                wptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (wr) begin
                    q_rob[wptr_q]  <= rob_q[STAGES-1];
                    q_res[wptr_q]  <= stage_res[STAGES-1];
                    q_link[wptr_q] <= link_q[STAGES-1];
                    wptr_q <= (wptr_q == QW'(Q_DEPTH - 1)) ? '0 : wptr_q + QW'(1);
                end
                if (pop) rptr_q <= (rptr_q == QW'(Q_DEPTH - 1)) ? '0 : rptr_q + QW'(1);
                if (wr && !pop)      count_q <= count_q + CW'(1);
                else if (!wr && pop) count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: stimulus pushes expected CDB beats, a monitor pops and compares.
module tb_alu_pipe;

    localparam logic [5:0] OpAdd   = 6'd1,  OpSub   = 6'd2,  OpXor   = 6'd3,  OpOr    = 6'd4;
    localparam logic [5:0] OpAnd   = 6'd5,  OpSll   = 6'd6,  OpSrl   = 6'd7,  OpSra   = 6'd8;
    localparam logic [5:0] OpSlt   = 6'd9,  OpSltu  = 6'd10, OpAddi  = 6'd11;
    localparam logic [5:0] OpSrai  = 6'd17, OpSlti  = 6'd18, OpBeq   = 6'd20;
    localparam logic [5:0] OpBne   = 6'd21, OpBlt   = 6'd22, OpBge   = 6'd23, OpBltu  = 6'd24;
    localparam logic [5:0] OpBgeu  = 6'd25, OpJalr  = 6'd26, OpLoad  = 6'd27;
    localparam logic [5:0] OpMul   = 6'd29, OpMulh  = 6'd30, OpMulhsu = 6'd31, OpMulhu = 6'd32;
    localparam logic [5:0] OpUndef = 6'd63;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, cdb_grant;
    logic        in_ready, cdb_valid;
    logic [5:0]  in_opcode;
    logic [31:0] in_lhs, in_rhs, in_pc, cdb_result, cdb_link;
    logic [3:0]  in_rob, cdb_rob;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
        logic [31:0] link;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int passes = 0;
    logic [3:0] next_rob = 4'd0;

    alu_pipe #(.XLEN(32), .ROB_W(4), .STAGES(2), .Q_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_pc(in_pc), .in_rob(in_rob),
        .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_rob(cdb_rob),
        .cdb_result(cdb_result), .cdb_link(cdb_link)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor: a beat presented with grant at a negedge is popped at the following posedge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst && rdy && !flush && cdb_valid && cdb_grant) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got rob 0x%0h result 0x%0h, expected no beat",
                             cdb_rob, cdb_result);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_rob", 32'(cdb_rob), 32'(e.tag));
                    check("beat_result", cdb_result, e.res);
                    check("beat_link", cdb_link, e.link);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] er, input logic [31:0] el);
        int  n = 0;
        bit  done = 1'b0;
        in_valid = 1'b1; in_opcode = op; in_lhs = a; in_rhs = b; in_pc = pc; in_rob = next_rob;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{tag: next_rob, res: er, link: el});
                done = 1'b1;
            end else if (++n > 50) begin
                checks++;
                $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        next_rob = next_rob + 4'd1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending beats, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        logic [31:0] mulhu_exp, mulh_exp, mulhsu_exp, mul_exp;
`ifdef ALU_PIPE_MUL_EN
        mulhu_exp = 32'hFFFF_FFFE; mulh_exp = 32'h0; mulhsu_exp = 32'hFFFF_FFFF; mul_exp = 32'd42;
`else
        mulhu_exp = 32'h0; mulh_exp = 32'h0; mulhsu_exp = 32'h0; mul_exp = 32'h0;
`endif
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_opcode = '0; in_lhs = '0; in_rhs = '0; in_pc = '0; in_rob = '0;

        // Reset state, with flush asserted to show reset dominates
        #12;
        flush = 1'b1;
        #1;
        check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        check("rst_cdb_rob", 32'(cdb_rob), 32'd0);
        check("rst_cdb_result", cdb_result, 32'd0);
        check("rst_cdb_link", cdb_link, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // ADD latency: accept at edge N, cdb_valid after N+2
        @(posedge clk); #1;
        cdb_grant = 1'b1;
        in_valid = 1'b1; in_opcode = OpAdd; in_lhs = 32'd5; in_rhs = 32'hFFFF_FFFF;
        in_pc = '0; in_rob = 4'd3;
        @(negedge clk);
        check("add_ready", 32'(in_ready), 32'd1);
        exp_q.push_back('{tag: 4'd3, res: 32'd4, link: 32'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_n1", 32'(cdb_valid), 32'd0);
        @(negedge clk);
        check("lat_n2", 32'(cdb_valid), 32'd0);
        @(negedge clk);
        check("lat_n3", 32'(cdb_valid), 32'd1);
        wait_idle();

        // Back-to-back directed vectors with grant held high
        next_rob = 4'd4;
        issue(OpSra,   32'h8000_0000, 32'd4,         0, 32'hF800_0000, 0);
        issue(OpSltu,  32'd1,         32'hFFFF_FFFF, 0, 32'd1,         0);
        issue(OpSub,   32'd3,         32'd5,         0, 32'hFFFF_FFFE, 0);
        issue(OpXor,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 32'hFF00_FF00, 0);
        issue(OpOr,    32'h1234_0000, 32'h0000_5678, 0, 32'h1234_5678, 0);
        issue(OpAnd,   32'hFF00_FF00, 32'h0F0F_0F0F, 0, 32'h0F00_0F00, 0);
        issue(OpSll,   32'd1,         32'h23,        0, 32'd8,         0);
        issue(OpSrl,   32'h8000_0000, 32'd31,        0, 32'd1,         0);
        issue(OpSlt,   32'hFFFF_FFFF, 32'd1,         0, 32'd1,         0);
        issue(OpSltu,  32'hFFFF_FFFF, 32'd1,         0, 32'd0,         0);
        issue(OpSlti,  32'd5,         32'hFFFF_FFFD, 0, 32'd0,         0);
        issue(OpBeq,   32'd7,         32'd7,         0, 32'd1,         0);
        issue(OpBne,   32'd7,         32'd7,         0, 32'd0,         0);
        issue(OpBlt,   32'h8000_0000, 32'd0,         0, 32'd1,         0);
        issue(OpBge,   32'h8000_0000, 32'd0,         0, 32'd0,         0);
        issue(OpBltu,  32'h8000_0000, 32'd0,         0, 32'd0,         0);
        issue(OpBgeu,  32'd5,         32'd5,         0, 32'd1,         0);
        issue(OpAddi,  32'hFFFF_FFFF, 32'd1,         0, 32'd0,         0);
        issue(OpSrai,  32'h7FFF_FFF0, 32'd4,         0, 32'h07FF_FFFF, 0);
        issue(OpLoad,  32'h1000,      32'h10,        0, 32'h1010,      0);
        issue(OpUndef, 32'd9,         32'd9,         0, 32'd0,         0);
        issue(OpJalr,  32'h1001,      32'd4,    32'h200, 32'h1004, 32'h204);
        issue(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, mulhu_exp,     0);
        issue(OpMulh,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, mulh_exp,      0);
        issue(OpMulhsu,32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, mulhsu_exp,    0);
        issue(OpMul,   32'd7,         32'd6,         0, mul_exp,       0);
        wait_idle();

        // Credit limit: grant low, stream ops
        cdb_grant = 1'b0;
        accepted = 0;
        in_opcode = OpAdd; in_lhs = 32'd100; in_rhs = '0; in_pc = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_rob = next_rob; in_rhs = 32'(i);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{tag: next_rob, res: 32'd100 + 32'(i), link: 32'd0});
                accepted++;
                next_rob = next_rob + 4'd1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("credit_accepts", 32'(accepted), 32'd4);
        @(negedge clk);
        check("credit_full_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
        @(negedge clk);
        check("credit_reopen_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        cdb_grant = 1'b1;
        wait_idle();

        // Flush with 3 queued and 1 in flight
        cdb_grant = 1'b0;
        issue(OpAdd, 32'd1, 32'd1, 0, 32'd2, 0);
        issue(OpAdd, 32'd2, 32'd2, 0, 32'd4, 0);
        issue(OpAdd, 32'd3, 32'd3, 0, 32'd6, 0);
        issue(OpAdd, 32'd4, 32'd4, 0, 32'd8, 0);
        @(posedge clk); #1;
        flush = 1'b1;
        in_valid = 1'b1; in_opcode = OpAdd; in_lhs = 32'd9; in_rhs = 32'd9; in_rob = 4'hF;
        @(negedge clk);
        check("flush_ready", 32'(in_ready), 32'd0);
        check("preflush_valid", 32'(cdb_valid), 32'd1);
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("postflush_valid", 32'(cdb_valid), 32'd0);
        check("postflush_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        cdb_grant = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("flush_empty", 32'(cdb_valid), 32'd0);

        // Flush offered with free credit: the op must still be dropped
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // rdy low freezes the queue and ignores grant
        cdb_grant = 1'b0;
        issue(OpOr, 32'hA0, 32'h05, 0, 32'hA5, 0);
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b0; cdb_grant = 1'b1;
        @(negedge clk);
        check("rdylow_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdylow_valid", 32'(cdb_valid), 32'd1);
        check("rdylow_result", cdb_result, 32'hA5);
        @(posedge clk); #1;
        rdy = 1'b1;
        wait_idle();

        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
